// File: rtl/ariane_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ariane_pkg
// Purpose  : Divider request types and serdiv opcode encodings.
// Revision : 1.0
// ============================================================================
package ariane_pkg;

  localparam int unsigned DIV_WIDTH         = 64;
  localparam int unsigned DIV_TRANS_ID_BITS = 3;

  localparam logic [1:0] DIV_UDIV = 2'b00;
  localparam logic [1:0] DIV_DIV  = 2'b01;
  localparam logic [1:0] DIV_UREM = 2'b10;
  localparam logic [1:0] DIV_REM  = 2'b11;

  // {word, opcode[1:0]}
  typedef logic [2:0] div_op_t;

  typedef struct packed {
    logic [DIV_WIDTH-1:0]         a;
    logic [DIV_WIDTH-1:0]         b;
    div_op_t                      op;
    logic [DIV_TRANS_ID_BITS-1:0] trans_id;
  } div_req_t;

endpackage
`default_nettype wire

// File: rtl/div_req_fifo.sv
`default_nettype none
// ============================================================================
// Module   : div_req_fifo
// Purpose  : DEPTH-entry request FIFO with synchronous flush.
// Revision : 1.0
// ============================================================================
module div_req_fifo
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     flush_i,
  input  logic     push_i,
  input  div_req_t data_i,
  input  logic     pop_i,
  output div_req_t data_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned      CNT_W    = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  div_req_t         mem_q [DEPTH];
  div_req_t         mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; count gates every read.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/div_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : div_issue_stage
// Purpose  : Operand prep / result return around serdiv.
//            Optional macro DIV_ZERO_FASTPATH_EN: local divide-by-zero completion.
// Revision : 1.0
// ============================================================================
module div_issue_stage
  import ariane_pkg::*;
#(
  parameter int unsigned WIDTH         = 64,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned DEPTH         = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [2:0]               req_op_i,
  input  logic [WIDTH-1:0]         req_a_i,
  input  logic [WIDTH-1:0]         req_b_i,
  input  logic [TRANS_ID_BITS-1:0] req_trans_id_i,
  output logic [TRANS_ID_BITS:0]   div_id_o,
  output logic [WIDTH-1:0]         div_op_a_o,
  output logic [WIDTH-1:0]         div_op_b_o,
  output logic [1:0]               div_opcode_o,
  output logic                     div_in_vld_o,
  input  logic                     div_in_rdy_i,
  output logic                     div_flush_o,
  input  logic                     div_out_vld_i,
  output logic                     div_out_rdy_o,
  input  logic [TRANS_ID_BITS:0]   div_id_i,
  input  logic [WIDTH-1:0]         div_res_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [WIDTH-1:0]         res_o,
  output logic [TRANS_ID_BITS-1:0] res_trans_id_o
);

  function automatic logic [WIDTH-1:0] sext32(input logic [31:0] v);
    return {{(WIDTH-32){v[31]}}, v};
  endfunction

  div_req_t                 req_ext, head;
  logic                     fifo_full, fifo_empty, push, pop;
  logic                     in_fire, out_fire;
  logic                     in_flight_q, in_flight_d;
  logic                     res_valid_q, res_valid_d;
  logic [WIDTH-1:0]         res_q, res_d;
  logic [TRANS_ID_BITS-1:0] res_id_q, res_id_d;

  always_comb begin
    req_ext = '{a: req_a_i, b: req_b_i, op: req_op_i, trans_id: req_trans_id_i};
    if (req_op_i[2]) begin
      if (req_op_i[0]) begin
        req_ext.a = sext32(req_a_i[31:0]);
        req_ext.b = sext32(req_b_i[31:0]);
      end else begin
        req_ext.a = {{(WIDTH-32){1'b0}}, req_a_i[31:0]};
        req_ext.b = {{(WIDTH-32){1'b0}}, req_b_i[31:0]};
      end
    end
  end

  assign req_ready_o = !fifo_full;
  assign push        = req_valid_i && req_ready_o && !flush_i;

  div_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (push),
    .data_i  (req_ext),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign div_op_a_o   = head.a;
  assign div_op_b_o   = head.b;
  assign div_opcode_o = head.op[1:0];
  assign div_id_o     = {head.op[2], head.trans_id};
  assign div_flush_o  = flush_i;

`ifdef DIV_ZERO_FASTPATH_EN
  logic             head_zero, zero_fire;
  logic [WIDTH-1:0] zero_raw;
  // A zero-divisor head never reaches serdiv; it waits until it can retire in order.
  assign head_zero    = !fifo_empty && (head.b == '0);
  assign zero_fire    = head_zero && !in_flight_q && !res_valid_q && !flush_i;
  assign zero_raw     = head.op[1] ? head.a : '1;
  assign div_in_vld_o = !fifo_empty && !head_zero;
  assign in_fire      = div_in_vld_o && div_in_rdy_i;
  assign pop          = in_fire || zero_fire;
`else
  assign div_in_vld_o = !fifo_empty;
  assign in_fire      = div_in_vld_o && div_in_rdy_i;
  assign pop          = in_fire;
`endif

  // Results with nothing in flight are leftovers from a flushed operation.
  assign div_out_rdy_o = !res_valid_q || res_ready_i;
  assign out_fire      = div_out_vld_i && div_out_rdy_o && in_flight_q && !flush_i;

  always_comb begin
    in_flight_d = in_flight_q;
    if (flush_i)       in_flight_d = 1'b0;
    else if (in_fire)  in_flight_d = 1'b1;
    else if (out_fire) in_flight_d = 1'b0;
  end

  always_comb begin
    res_d       = res_q;
    res_id_d    = res_id_q;
    res_valid_d = res_valid_q;
    if (flush_i) begin
      res_valid_d = 1'b0;
    end else if (out_fire) begin
      res_d       = div_id_i[TRANS_ID_BITS] ? sext32(div_res_i[31:0]) : div_res_i;
      res_id_d    = div_id_i[TRANS_ID_BITS-1:0];
      res_valid_d = 1'b1;
    end
`ifdef DIV_ZERO_FASTPATH_EN
    else if (zero_fire) begin
      res_d       = head.op[2] ? sext32(zero_raw[31:0]) : zero_raw;
      res_id_d    = head.trans_id;
      res_valid_d = 1'b1;
    end
`endif
    else if (res_ready_i) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_flight_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
      res_id_q    <= '0;
    end else begin
      in_flight_q <= in_flight_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
      res_id_q    <= res_id_d;
    end
  end

  assign res_valid_o    = res_valid_q;
  assign res_o          = res_q;
  assign res_trans_id_o = res_id_q;

endmodule
`default_nettype wire

// File: doc/div_issue_stage.md
Name: div_issue_stage

Overview:
- Operand-preparation and result-return stage wrapped around serdiv.
- Upstream, it accepts divide/remainder requests from the issue logic, buffers them in a small FIFO, and applies RV64 word-op operand extension. It then maps each request to serdiv's 2-bit opcode and drives serdiv's in_vld/in_rdy handshake.
- Downstream, it captures serdiv results into an output register, sign-extends word-op results, and presents them to writeback with a valid/ready handshake.

Parameters:
- WIDTH, 64, datapath width; must equal serdiv WIDTH.
- TRANS_ID_BITS, 3, width of the scoreboard transaction ID.
- DEPTH, 2, request FIFO entries; power of two, ≥1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  pipeline flush
- req_valid_i  in  1  request valid
- req_ready_o  out  1  FIFO not full
- req_op_i  in  3  [1:0] serdiv opcode (00 udiv, 01 div, 10 urem, 11 rem); [2] word op
- req_a_i  in  WIDTH  dividend
- req_b_i  in  WIDTH  divisor
- req_trans_id_i  in  TRANS_ID_BITS  transaction ID
- div_id_o  out  TRANS_ID_BITS+1  {word, trans_id} to serdiv id_i
- div_op_a_o  out  WIDTH  to serdiv op_a_i
- div_op_b_o  out  WIDTH  to serdiv op_b_i
- div_opcode_o  out  2  to serdiv opcode_i
- div_in_vld_o  out  1  to serdiv in_vld_i
- div_in_rdy_i  in  1  from serdiv in_rdy_o
- div_flush_o  out  1  to serdiv flush_i
- div_out_vld_i  in  1  from serdiv out_vld_o
- div_out_rdy_o  out  1  to serdiv out_rdy_i
- div_id_i  in  TRANS_ID_BITS+1  from serdiv id_o
- div_res_i  in  WIDTH  from serdiv res_o
- res_valid_o  out  1  result valid
- res_ready_i  in  1  writeback ready
- res_o  out  WIDTH  result
- res_trans_id_o  out  TRANS_ID_BITS  result ID

Behaviour:

Interface and reset:
- One clock, clk_i. Reset is synchronous and active-high on rst_i.
- rst_i clears the FIFO pointers and count, in_flight, and res_valid_o.
- Reset values: res_o=0, res_trans_id_o=0, div_in_vld_o=0, req_ready_o=1 in the cycle after reset.

Request path:
- Enqueue when req_valid_i && req_ready_o. req_ready_o = (count != DEPTH); it is registered-state-based with no combinational path from downstream ready.
- Operand extension is applied at enqueue:
  - Word op, signed (op[0]=1): a = sext(req_a_i[31:0]), b = sext(req_b_i[31:0]).
  - Word op, unsigned: zero-extend both operands.
  - Otherwise: operands pass unchanged.
- FIFO head drives div_op_*_o, div_opcode_o and div_id_o. div_in_vld_o = (count != 0).
- Dequeue on div_in_vld_o && div_in_rdy_i.
- Simultaneous enqueue and dequeue at full is not allowed, because ready is based on count.
- Simultaneous enqueue and dequeue when not full: count is unchanged and both pointers advance, wrapping modulo DEPTH.
- in_flight is set on the serdiv input handshake and cleared on the serdiv output handshake.

Result path:
- div_out_rdy_o = !res_valid_o || res_ready_i.
- On div_out_vld_i && div_out_rdy_o, load the result register:
  - res_o = div_id_i[TRANS_ID_BITS] ? sext(div_res_i[31:0]) : div_res_i
  - res_trans_id_o = div_id_i[TRANS_ID_BITS-1:0]
  - res_valid_o = 1
- res_valid_o clears on res_ready_i unless a new result loads in the same cycle; back-to-back results are supported at one per cycle.
- The result register holds stable while res_valid_o && !res_ready_i.

Flush:
- div_flush_o = flush_i, combinational.
- Flush clears the FIFO, in_flight and res_valid_o in the next cycle.
- A request presented in the flush cycle is dropped. A result arriving in the flush cycle is not captured.

Optional Feature:

DIV_ZERO_FASTPATH_EN:
- When defined, a FIFO head with divisor == 0 and !in_flight && !res_valid_o is completed locally in one cycle. It is dequeued without asserting div_in_vld_o and written to the result register:
  - div/divu: result = all-ones.
  - rem/remu: result = extended dividend.
  - Word ops: result is taken from [31:0] and then sign-extended.
- In-order completion is guaranteed by the !in_flight condition.
- When undefined, all requests go through serdiv, and the result register only loads from serdiv.

Decomposition:
- ariane_pkg holds:
  - the div_op_t typedef (3-bit {word, opcode}) and the opcode constants DIV_UDIV=2'b00, DIV_DIV=2'b01, DIV_UREM=2'b10, DIV_REM=2'b11;
  - the div_req_t struct {a, b, op, trans_id}.
- One sub-module, div_req_fifo: parameterised DEPTH FIFO of div_req_t with count, full and empty.
- Result register and extension logic stay in the top module.

Test Plan:
1. DIV a=-20, b=3, id=2 → serdiv opcode 01, operands unchanged; res_o=-6 (0xFFFF_FFFF_FFFF_FFFA), res_trans_id_o=2.
2. DIVW a=0x0000_0001_8000_0000, b=0xFFFF_FFFF → serdiv sees a=0xFFFF_FFFF_8000_0000, b=-1; res_o=0xFFFF_FFFF_8000_0000.
3. Backpressure: DEPTH+1 back-to-back requests with div_in_rdy_i=0 → req_ready_o drops after DEPTH accepts. Then hold res_ready_i=0 → res_o stable and div_out_rdy_o=0 until release.
4. Flush with 2 queued requests and 1 in flight → next cycle count=0, res_valid_o=0, div_flush_o pulses; no stale result ever appears on res_valid_o.
5. REMUW a=0xFFFF_FFFF_0000_0007, b=0 → result 7. With DIV_ZERO_FASTPATH_EN, it completes with div_in_vld_o never asserted, one cycle after reaching the FIFO head.
6. Reset asserted mid-division → next cycle FIFO empty, res_valid_o=0, req_ready_o=1.
